// File: rtl/ll_sc_monitor_if.sv
// Datapath / dcache / snoop bundle seen by the LL/SC monitor.
// master: datapath+cache+bus side, slave: the monitor itself.
interface ll_sc_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic              datomic;
    logic [ADDR_W-1:0] dmemaddr;
    logic              cache_dhit;
    logic              snoop_valid;
    logic [ADDR_W-1:0] snoop_addr;
    logic              cache_wen;
    logic              cache_ren;
    logic              dhit_o;
    logic [WORD_W-1:0] sc_result;
    logic              link_valid;
    logic [ADDR_W-1:0] link_addr;

    modport master (
        output dmemREN, dmemWEN, datomic, dmemaddr,
        output cache_dhit, snoop_valid, snoop_addr,
        input  cache_wen, cache_ren, dhit_o, sc_result,
        input  link_valid, link_addr
    );

    modport slave (
        input  dmemREN, dmemWEN, datomic, dmemaddr,
        input  cache_dhit, snoop_valid, snoop_addr,
        output cache_wen, cache_ren, dhit_o, sc_result,
        output link_valid, link_addr
    );
endinterface

// File: rtl/ll_sc_monitor.sv
// LL/SC link monitor between datapath memory port and dcache.
// Ports: CLK, RST (sync, active-high), bus (ll_sc_monitor_if.slave).
module ll_sc_monitor #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic           CLK,
    input  logic           RST,
    ll_sc_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SC_WRITE,
        SC_FAIL
    } state_t;

    state_t state;
    logic   link_vld;
    logic [ADDR_W-1:0] link_a;

    function automatic logic word_eq(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] b
    );
        return a[ADDR_W-1:2] == b[ADDR_W-1:2];
    endfunction

    logic is_ll;
    logic is_sc;
    logic is_sw;
    logic snoop_hit;
    logic snoop_new;
    logic sc_ok;

    assign is_ll = bus.dmemREN & bus.datomic;
    assign is_sc = bus.dmemWEN & bus.datomic;
    assign is_sw = bus.dmemWEN & ~bus.datomic;
    assign snoop_hit = bus.snoop_valid & link_vld &
                       word_eq(bus.snoop_addr, link_a);
    // Snoop against the word an LL is linking right now.
    assign snoop_new = bus.snoop_valid &
                       word_eq(bus.snoop_addr, bus.dmemaddr);
    assign sc_ok = link_vld & word_eq(bus.dmemaddr, link_a) & ~snoop_hit;

    always_comb begin
        bus.cache_ren = 1'b0;
        bus.cache_wen = 1'b0;
        bus.dhit_o    = 1'b0;
        bus.sc_result = '0;
        unique case (state)
            IDLE: begin
                bus.cache_ren = bus.dmemREN;
                bus.cache_wen = is_sw;
                // SC is held off the cache until the decision cycle.
                bus.dhit_o    = bus.cache_dhit & ~is_sc;
            end
            SC_WRITE: begin
                bus.cache_wen = 1'b1;
                bus.dhit_o    = bus.cache_dhit;
                bus.sc_result = WORD_W'(bus.cache_dhit);
            end
            SC_FAIL: begin
                bus.dhit_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            link_vld <= 1'b0;
            link_a   <= '0;
        end else begin
            // Remote write to the linked word kills the link in any state.
            if (snoop_hit)
                link_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (is_sc) begin
                        state <= sc_ok ? SC_WRITE : SC_FAIL;
                    end else if (is_ll & bus.cache_dhit) begin
                        link_vld <= ~snoop_new;
                        link_a   <= {bus.dmemaddr[ADDR_W-1:2], 2'b00};
                    end else if (is_sw & bus.cache_dhit &
                                 word_eq(bus.dmemaddr, link_a)) begin
                        link_vld <= 1'b0;
                    end
                end
                SC_WRITE: begin
                    if (bus.cache_dhit) begin
                        state    <= IDLE;
                        link_vld <= 1'b0;
                    end
                end
                SC_FAIL: begin
                    state    <= IDLE;
                    link_vld <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.link_valid = link_vld;
    assign bus.link_addr  = link_a;
endmodule

// File: tb/tb_ll_sc_monitor.sv
// Directed bench for ll_sc_monitor.
// Drives the bus interface, checks outputs against hand-computed values.
module tb_ll_sc_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ll_sc_monitor_if #(.ADDR_W(32), .WORD_W(32)) bus ();

    ll_sc_monitor #(.ADDR_W(32), .WORD_W(32)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    // An SC that has not completed must be held until dhit_o.
    a_sc_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.dmemWEN && bus.datomic && !bus.dhit_o) |=>
        (bus.dmemWEN && bus.datomic && $stable(bus.dmemaddr)));

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.dmemREN     = 1'b0;
        bus.dmemWEN     = 1'b0;
        bus.datomic     = 1'b0;
        bus.dmemaddr    = '0;
        bus.cache_dhit  = 1'b0;
        bus.snoop_valid = 1'b0;
        bus.snoop_addr  = '0;
    endtask

    task automatic ll(input logic [31:0] a);
        bus.dmemREN    = 1'b1;
        bus.datomic    = 1'b1;
        bus.dmemaddr   = a;
        bus.cache_dhit = 1'b1;
        tick();
        clr();
    endtask

    task automatic sc_req(input logic [31:0] a);
        bus.dmemWEN    = 1'b1;
        bus.datomic    = 1'b1;
        bus.dmemaddr   = a;
        bus.cache_dhit = 1'b0;
    endtask

    task automatic sc_fail(input string tag, input logic [31:0] a);
        sc_req(a);
        #1;
        check({tag, "_d_wen"}, 32'(bus.cache_wen), 0);
        check({tag, "_d_hit"}, 32'(bus.dhit_o), 0);
        tick();
        check({tag, "_f_hit"}, 32'(bus.dhit_o), 1);
        check({tag, "_f_res"}, bus.sc_result, 0);
        check({tag, "_f_wen"}, 32'(bus.cache_wen), 0);
        check({tag, "_f_ren"}, 32'(bus.cache_ren), 0);
        tick();
        clr();
        #1;
        check({tag, "_lv"}, 32'(bus.link_valid), 0);
        check({tag, "_hit0"}, 32'(bus.dhit_o), 0);
    endtask

    initial begin
        clr();
        rst = 1'b1;
        tick();
        tick();
        check("rst_lv", 32'(bus.link_valid), 0);
        check("rst_la", bus.link_addr, 0);
        check("rst_wen", 32'(bus.cache_wen), 0);
        check("rst_hit", 32'(bus.dhit_o), 0);
        check("rst_res", bus.sc_result, 0);
        rst = 1'b0;
        tick();

        // LL then successful SC
        bus.dmemREN    = 1'b1;
        bus.datomic    = 1'b1;
        bus.dmemaddr   = 32'h100;
        bus.cache_dhit = 1'b1;
        #1;
        check("ll_ren", 32'(bus.cache_ren), 1);
        check("ll_hit", 32'(bus.dhit_o), 1);
        tick();
        clr();
        check("ll_lv", 32'(bus.link_valid), 1);
        check("ll_la", bus.link_addr, 32'h100);
        sc_req(32'h100);
        #1;
        check("sc1_wen", 32'(bus.cache_wen), 0);
        check("sc1_hit", 32'(bus.dhit_o), 0);
        tick();
        check("sc2_wen", 32'(bus.cache_wen), 1);
        check("sc2_ren", 32'(bus.cache_ren), 0);
        check("sc2_hit", 32'(bus.dhit_o), 0);
        check("sc2_res", bus.sc_result, 0);
        bus.cache_dhit = 1'b1;
        #1;
        check("sc3_hit", 32'(bus.dhit_o), 1);
        check("sc3_res", bus.sc_result, 1);
        tick();
        clr();
        #1;
        check("sc_lv", 32'(bus.link_valid), 0);
        check("sc_res0", bus.sc_result, 0);

        // snoop to same word kills link
        ll(32'h100);
        bus.snoop_valid = 1'b1;
        bus.snoop_addr  = 32'h102;
        tick();
        clr();
        check("snp_lv", 32'(bus.link_valid), 0);
        sc_fail("snp", 32'h100);

        // SC to another word, then SC with stale link
        ll(32'h100);
        sc_fail("oth", 32'h104);
        sc_fail("stale", 32'h100);

        // snoop and SC decision in the same cycle
        ll(32'h100);
        bus.snoop_valid = 1'b1;
        bus.snoop_addr  = 32'h100;
        sc_fail("snsc", 32'h100);

        // LL racing a snoop
        bus.snoop_valid = 1'b1;
        bus.snoop_addr  = 32'h200;
        ll(32'h200);
        check("race_lv", 32'(bus.link_valid), 0);
        bus.snoop_valid = 1'b1;
        bus.snoop_addr  = 32'h300;
        ll(32'h200);
        check("nrace_lv", 32'(bus.link_valid), 1);
        check("nrace_la", bus.link_addr, 32'h200);
        ll(32'h20B);
        check("ll2_la", bus.link_addr, 32'h208);

        // local SW to the linked word
        ll(32'h100);
        bus.dmemWEN    = 1'b1;
        bus.dmemaddr   = 32'h100;
        bus.cache_dhit = 1'b1;
        #1;
        check("sw_wen", 32'(bus.cache_wen), 1);
        check("sw_hit", 32'(bus.dhit_o), 1);
        tick();
        clr();
        check("sw_lv", 32'(bus.link_valid), 0);

        // snoop during SC_WRITE clears link but SC still succeeds
        ll(32'h100);
        sc_req(32'h100);
        tick();
        bus.snoop_valid = 1'b1;
        bus.snoop_addr  = 32'h100;
        tick();
        bus.snoop_valid = 1'b0;
        check("scw_lv", 32'(bus.link_valid), 0);
        check("scw_wen", 32'(bus.cache_wen), 1);
        bus.cache_dhit = 1'b1;
        #1;
        check("scw_res", bus.sc_result, 1);
        tick();
        clr();

        // reset during SC_WRITE
        ll(32'h100);
        sc_req(32'h100);
        tick();
        check("rsc_wen1", 32'(bus.cache_wen), 1);
        rst = 1'b1;
        tick();
        check("rsc_wen", 32'(bus.cache_wen), 0);
        check("rsc_hit", 32'(bus.dhit_o), 0);
        check("rsc_lv", 32'(bus.link_valid), 0);
        clr();
        rst = 1'b0;
        tick();
        check("rsc_idle", 32'(bus.cache_wen), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
